mux_scan_sampler: RTL and testbench
===================================

Name: mux_scan_sampler

Overview:
- Sequencer that sits around the team's 4:1 mux. It drives the mux select lines, waits a programmable settle time per channel, and samples the mux output.
- It assembles the four samples into a 4-bit frame, bit k = channel k.
- Frames are delivered downstream over a valid/ready handshake.
- Supports a single scan per start pulse, or continuous back-to-back scans.

Parameters:
- DWELL, 2, cycles each select value is held before mux_y is sampled; legal range 1..15.
- NUM_CH, 4, channel count; fixed at 4 (matches the 4:1 mux).
- SEL_W, 2, select width, log2(NUM_CH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin scanning; sampled only in IDLE.
- cont  input  1  continuous mode; sampled when a frame is handed to the output register.
- sel  output  SEL_W  mux select; registered.
- mux_y  input  1  mux output.
- frame  output  NUM_CH  assembled sample word; bit k = channel k.
- frame_valid  output  1  frame holds unconsumed data.
- frame_ready  input  1  downstream accepts the frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, sel=0, dwell count=0, assembly reg=0, frame=0, frame_valid=0, busy=0.
- States:
  - IDLE: start=1 → SETTLE with sel=0, cnt=0.
  - SETTLE: cnt increments each cycle. At the edge where cnt==DWELL-1, mux_y is written into assembly bit[sel].
    - If sel<3: sel+1, cnt=0, stay in SETTLE.
    - If sel==3: → DONE, sel held at 3.
  - DONE: transfer assembly→frame and set frame_valid=1 when the output slot is free, i.e. frame_valid==0 or frame_ready==1 this cycle.
    - On transfer: cont=1 → SETTLE with sel=0, cnt=0; cont=0 → IDLE with sel=0.
    - Otherwise stay in DONE (stall). No data is lost and no overrun occurs.
- Output handshake:
  - frame_valid clears on frame_valid & frame_ready, unless a new frame loads in the same cycle, in which case it stays 1 with the new data.
  - frame is stable while frame_valid=1 and frame_ready=0.
- Latency: with start sampled at edge E0, the last capture is at E0+4·DWELL and frame_valid rises at E0+4·DWELL+1 (DWELL=2 → 9 cycles).
- Continuous mode, unstalled: one frame every 4·DWELL+1 cycles.
- start while busy is ignored. cont=0 mid-scan finishes the current frame, then goes to IDLE.
- Channel settling: sel changes at the edge after a capture, so mux_y must settle within DWELL cycles. DWELL=1 means mux_y is sampled at the end of the same cycle sel changes.
- Reset mid-scan: immediate return to reset values. A partial frame is discarded and frame_valid drops.
- Arithmetic: cnt is 4 bits and wraps only through its explicit clear; sel is SEL_W bits and never wraps past 3 inside SETTLE.

Decomposition:
- Shared package mux_scan_pkg: NUM_CH, SEL_W, DWELL_MAX=15, and the state enum {IDLE, SETTLE, DONE}.
- Sub-module mux_scan_timer: dwell counter with clear/enable inputs and a terminal-count output (cnt==DWELL-1).
- FSM, assembly register and output register stay in the top module.

Test Plan:
- Single scan: DWELL=2, bench mux models y=i[sel] with i=4'b1010, start pulse, cont=0 → frame=4'b1010, frame_valid rises 9 cycles after the start edge, busy drops the same edge; sel sequence 0,0,1,1,2,2,3,3.
- Backpressure: frame_ready=0 for 20 cycles in continuous mode, i=4'b0110 → frame_valid held, frame stable at 4'b0110, FSM parked in DONE; frame_ready=1 → one accept, next frame follows without a gap beyond the load cycle.
- Continuous streaming: cont=1, frame_ready=1, i changes 4'b0001 → 4'b1000 between scans → consecutive frames 4'b0001 then 4'b1000, spaced 9 cycles apart.
- Reset mid-scan: assert rst_n=0 while sel=2 → sel=0, frame_valid=0, busy=0 asynchronously; after release, start → clean frame.
- DWELL=1 corner plus ignored start: start held high throughout, i=4'b1111 → frame 4'b1111 after 5 cycles; a second start while busy does not restart the scan.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the mux scan sequencer.
package mux_scan_pkg;

  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;
  localparam int DWELL_MAX = 15;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_timer.sv
// Dwell counter: counts while enabled, clears on request, flags cnt == DWELL-1.
module mux_scan_timer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // Out-of-range settings are clamped to the legal 1..DWELL_MAX window.
  localparam int DWELL_C = (DWELL < 1) ? 1 : ((DWELL > DWELL_MAX) ? DWELL_MAX : DWELL);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first, so no path leaves cnt_d unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CNT_W'(DWELL_C - 1));

endmodule

// File: rtl/mux_scan_sampler.sv
// Scans a 4:1 mux channel by channel, assembles a 4-bit frame and hands it
// downstream over valid/ready, in single-shot or continuous mode.
module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_y,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy
);

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [NUM_CH-1:0]  asm_q;
  logic [NUM_CH-1:0]  frame_q;
  logic               fv_q;
  logic               busy_q;
  logic               tc;
  logic               in_settle;
  logic               slot_free;
  logic               load;

  assign in_settle = (state_q == SETTLE);
  assign slot_free = !fv_q || frame_ready;
  assign load      = (state_q == DONE) && slot_free;

  // The counter restarts on every capture and stays cleared outside SETTLE.
  mux_scan_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!in_settle || tc),
    .en    (in_settle),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      asm_q   <= '0;
      frame_q <= '0;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: every register here uses <=, so all decisions see the pre-edge values.
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SETTLE;
            sel_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (tc) begin
            asm_q[sel_q] <= mux_y;
            if (sel_q == SEL_W'(NUM_CH - 1)) state_q <= DONE;
            else                             sel_q   <= sel_q + SEL_W'(1);
          end
        end
        DONE: begin
          // Park here until the output slot is free; the finished frame is never dropped.
          if (slot_free) begin
            frame_q <= asm_q;
            sel_q   <= '0;
            if (cont) begin
              state_q <= SETTLE;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase

      if (load)             fv_q <= 1'b1;
      else if (frame_ready) fv_q <= 1'b0;
    end
  end

  assign sel         = sel_q;
  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: DWELL=2 and DWELL=1 instances driven by a mux model,
// frames predicted from the per-edge history of the mux inputs.
module tb_mux_scan_sampler;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start_a, cont_a, ready_a, y_a, fv_a, busy_a;
  logic [1:0] sel_a;
  logic [3:0] ia, frame_a;

  logic       start_b, cont_b, ready_b, y_b, fv_b, busy_b;
  logic [1:0] sel_b;
  logic [3:0] ib, frame_b;

  int         cyc    = 0;
  int         total  = 0;
  int         passed = 0;
  int         fails  = 0;
  logic [3:0] ihist [int];

  always #5 clk = ~clk;

  assign y_a = ia[sel_a];
  assign y_b = ib[sel_b];

  mux_scan_sampler #(.DWELL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cont(cont_a), .sel(sel_a),
    .mux_y(y_a), .frame(frame_a), .frame_valid(fv_a), .frame_ready(ready_a), .busy(busy_a)
  );

  mux_scan_sampler #(.DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cont(cont_b), .sel(sel_b),
    .mux_y(y_b), .frame(frame_b), .frame_valid(fv_b), .frame_ready(ready_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; records what the mux inputs of instance A were at that edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    ihist[cyc] = ia;
    #1;
  endtask

  // Channel k is captured at edge s0 + (k+1)*d from the input pattern present then.
  function automatic logic [3:0] exp_frame(input int s0, input int d);
    logic [3:0] f;
    logic [3:0] h;
    for (int k = 0; k < 4; k++) begin
      h    = ihist[s0 + (k + 1) * d];
      f[k] = h[k];
    end
    return f;
  endfunction

  task automatic wait_fv(input string tag, input bit use_b, input bit rnd, input int budget,
                         output int at);
    int n;
    n = 0;
    while (((use_b ? fv_b : fv_a) !== 1'b1) && n < budget) begin
      if (rnd) ia = 4'($urandom);
      step();
      n++;
    end
    at = cyc;
    check(tag, use_b ? fv_b : fv_a, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         s0, s1, at1, at2, n;
    logic [3:0] held;
    bit         stable;

    rst_n   = 1'b0;
    start_a = 0; cont_a = 0; ready_a = 0; ia = '0;
    start_b = 0; cont_b = 0; ready_b = 0; ib = '0;
    repeat (2) step();
    check("rst_sel",   sel_a,   0);
    check("rst_frame", frame_a, 0);
    check("rst_valid", fv_a,    0);
    check("rst_busy",  busy_a,  0);
    check("rst_b_valid", fv_b,  0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Single scan, with an extra start pulse mid-scan that must be ignored.
    ia = 4'b1010; cont_a = 0; ready_a = 0;
    start_a = 1; step(); s0 = cyc; start_a = 0;
    check("single_sel0", sel_a, 0);
    for (int j = 1; j < 8; j++) begin
      if (j == 3) start_a = 1;
      step();
      start_a = 0;
      check($sformatf("single_sel%0d", j), sel_a, j / 2);
    end
    step();
    check("single_valid_e8", fv_a, 0);
    check("single_busy_e8",  busy_a, 1);
    step();
    check("single_valid_e9", fv_a, 1);
    check("single_latency",  cyc - s0, 9);
    check("single_frame",    frame_a, exp_frame(s0, 2));
    check("single_busy_e9",  busy_a, 0);
    ready_a = 1; step();
    check("single_accept", fv_a, 0);
    ready_a = 0;

    // Backpressure in continuous mode.
    ia = 4'b0110; cont_a = 1; ready_a = 0;
    start_a = 1; step(); s0 = cyc; start_a = 0;
    wait_fv("bp_first_valid", 0, 0, 40, at1);
    check("bp_latency", at1 - s0, 9);
    check("bp_frame",   frame_a, exp_frame(s0, 2));
    s1 = cyc; ia = 4'b1001;
    held = frame_a; stable = 1;
    repeat (20) begin
      step();
      if (frame_a !== held || fv_a !== 1'b1) stable = 0;
    end
    check("bp_stable",      stable, 1);
    check("bp_frame_held",  frame_a, exp_frame(s0, 2));
    check("bp_parked_sel",  sel_a, 3);
    check("bp_parked_busy", busy_a, 1);
    cont_a = 0; ready_a = 1; step();
    check("bp_reload_valid", fv_a, 1);
    check("bp_reload_frame", frame_a, exp_frame(s1, 2));
    step();
    check("bp_drain_valid", fv_a, 0);
    check("bp_drain_busy",  busy_a, 0);

    // Continuous streaming with the pattern changing between scans.
    ia = 4'b0001; cont_a = 1; ready_a = 1;
    start_a = 1; step(); s0 = cyc; start_a = 0;
    wait_fv("stream_v1", 0, 0, 40, at1);
    check("stream_lat1",   at1 - s0, 9);
    check("stream_frame1", frame_a, exp_frame(s0, 2));
    s1 = cyc; ia = 4'b1000; cont_a = 0;
    step();
    wait_fv("stream_v2", 0, 0, 40, at2);
    check("stream_gap",    at2 - at1, 9);
    check("stream_frame2", frame_a, exp_frame(s1, 2));
    step();

    // Random patterns changing every cycle during the scan.
    ready_a = 1; cont_a = 0;
    for (int r = 0; r < 4; r++) begin
      ia = 4'($urandom);
      start_a = 1; step(); s0 = cyc; start_a = 0;
      wait_fv($sformatf("rand%0d_valid", r), 0, 1, 40, at1);
      check($sformatf("rand%0d_lat", r),   at1 - s0, 9);
      check($sformatf("rand%0d_frame", r), frame_a, exp_frame(s0, 2));
    end
    step();

    // Reset in the middle of the second continuous scan.
    ia = 4'b0101; cont_a = 1; ready_a = 0;
    start_a = 1; step(); start_a = 0;
    wait_fv("rst_mid_v1", 0, 0, 40, at1);
    n = 0;
    while (sel_a !== 2'd2 && n < 20) begin step(); n++; end
    check("rst_mid_reach_sel2", sel_a, 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_sel",   sel_a,  0);
    check("rst_mid_valid", fv_a,   0);
    check("rst_mid_busy",  busy_a, 0);
    check("rst_mid_frame", frame_a, 0);
    @(negedge clk) rst_n = 1'b1;
    cont_a = 0; ready_a = 1; ia = 4'b0011;
    step();
    start_a = 1; step(); s0 = cyc; start_a = 0;
    wait_fv("rst_after_valid", 0, 0, 40, at1);
    check("rst_after_lat",   at1 - s0, 9);
    check("rst_after_frame", frame_a, exp_frame(s0, 2));

    // DWELL=1 instance with start held high throughout.
    ib = 4'b1111; cont_b = 0; ready_b = 1;
    start_b = 1; step(); s0 = cyc;
    check("d1_sel0", sel_b, 0);
    for (int j = 1; j < 4; j++) begin
      step();
      check($sformatf("d1_sel%0d", j), sel_b, j);
    end
    wait_fv("d1_valid", 1, 0, 20, at1);
    check("d1_latency", at1 - s0, 5);
    check("d1_frame",   frame_b, 4'b1111);
    check("d1_busy_end", busy_b, 0);
    step();
    wait_fv("d1_valid2", 1, 0, 20, at2);
    check("d1_restart_gap", at2 - at1, 6);
    start_b = 0;
    repeat (2) step();
    check("d1_idle_busy", busy_b, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
